fp32_accum: RTL and testbench
=============================

FP32_ACCUM -- requirements
Module: fp32_accum

Interface
REQ-001 SHALL have parameter LEN, default 4, meaning the maximum number of terms per accumulation group (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset; it is asynchronous and active-high.
REQ-004 SHALL have port clear, input, 1, meaning synchronous abort of the current group.
REQ-005 SHALL have port in_valid, input, 1, meaning an fp32 term is presented.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a term this cycle.
REQ-007 SHALL have port in_data, input, 32, meaning the fp32 term (sign, exp[30:23], frac[22:0]).
REQ-008 SHALL have port in_last, input, 1, meaning the accepted term closes the group early.
REQ-009 SHALL have port out_valid, output, 1, meaning a group result is held.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have port out_data, output, 32, meaning the fp32 group sum.
REQ-012 SHALL have port out_cnt, output, 8, meaning the number of terms summed into out_data.
REQ-013 SHALL have port out_special, output, 1, meaning the exponent field of the running sum was 8'hFF (Inf/NaN) at any point in the group (sticky).

Function
REQ-014 SHALL implement a two-state FSM with states ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 SHALL define accept as in_valid & in_ready; on accept, acc <= fpADD32(acc, in_data), cnt <= cnt+1, and the sticky special flag ORs in (&sum[30:23]).
REQ-016 SHALL add combinationally within the accept cycle, so each term costs exactly one cycle; terms may be accepted back-to-back.
REQ-017 SHALL transition ACCUM->HOLD on an accept where in_last=1 or cnt==LEN-1; in the same edge it SHALL load out_data=new sum, out_cnt=cnt+1 and out_special=updated flag.
REQ-018 SHALL, in HOLD, keep out_data, out_cnt and out_special stable until out_valid & out_ready.
REQ-019 SHALL, on out_valid & out_ready, return to ACCUM with acc=32'h00000000, cnt=0 and flag=0; the next term is accepted no earlier than the following cycle.
REQ-020 SHALL, when clear=1 in either state, set acc=0, cnt=0 and flag=0, drop any held result (out_valid=0) and go to ACCUM; clear has priority over accept and over an output handshake in the same cycle.
REQ-021 SHALL have an 8-bit cnt that never wraps, because the group closes at LEN terms.
REQ-022 SHALL NOT alter the adder's arithmetic: it uses truncation, performs no leading-zero renormalisation and emits canonical NaN 32'h7FC00000.
REQ-023 SHALL produce a group minimum latency of one cycle from the last accepted term to out_valid.

Reset
REQ-024 SHALL, while rst=1, force state=ACCUM, acc=0, cnt=0, flag=0, out_valid=0, out_data=32'h0, out_cnt=0 and out_special=0.
REQ-025 SHALL hold in_ready=0 while rst=1 and drive it to 1 from the first clock after deassertion.
REQ-026 SHALL discard the partial group and any held result on reset mid-operation.

Structure
REQ-027 SHALL take FP32_POS_ZERO, FP32_QNAN (32'h7FC00000), FP32_EXP_MAX (8'hFF) and the state enum from a shared fp package.
REQ-028 SHALL instantiate exactly one fpADD32 as the sole sub-module, with A=acc, B=in_data and S driving the next-acc mux.

Verification
REQ-029 SHALL cover: LEN=4 with terms 3F800000, 40000000, 40400000, 40800000 -> out_data=41200000, out_cnt=4, out_special=0, out_valid one cycle after the 4th accept.
REQ-030 SHALL cover: terms 40000000 then 40400000 with in_last on the 2nd -> out_data=40A00000, out_cnt=2.
REQ-031 SHALL cover: out_ready held low 3 cycles in HOLD -> out_data stable, in_ready=0, in_valid ignored; the handshake then returns in_ready=1 next cycle.
REQ-032 SHALL cover: terms 7F800000 then 3F800000 with in_last -> out_data=7F800000, out_special=1; a following group of 3F800000 x4 -> 40800000, out_special=0.
REQ-033 SHALL cover: clear asserted after 2 accepted terms, and again in HOLD with out_ready=1 -> no out_valid for that group; next group 3F800000 x4 -> 40800000.
REQ-034 SHALL cover: rst pulsed asynchronously mid-group -> all outputs 0 immediately; after release the group 3F800000 x4 -> 40800000.

Source files
------------

// File: rtl/fp32_accum_pkg.sv
// Shared fp32 constants, helpers and accumulator state encoding.
package fp32_accum_pkg;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == FP32_EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] x);
    return (x[30:23] == FP32_EXP_MAX) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic fp_is_zero(input logic [31:0] x);
    return x[30:23] == 8'd0;
  endfunction

endpackage

// File: rtl/fp32_accum_add.sv
// Combinational fp32 adder: truncating alignment, no left renormalisation,
// subnormal inputs treated as zero, canonical quiet NaN on invalid results.
module fpADD32
  import fp32_accum_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S
);

  logic        swap;
  logic [31:0] big;
  logic [31:0] sml;
  logic [7:0]  ediff;
  logic [24:0] mbig;
  logic [24:0] msml;
  logic [24:0] mshf;
  logic [24:0] msum;
  logic        same;

  always_comb begin
    swap  = B[30:0] > A[30:0];
    big   = swap ? B : A;
    sml   = swap ? A : B;
    same  = big[31] == sml[31];
    ediff = big[30:23] - sml[30:23];
    mbig  = {2'b01, big[22:0]};
    msml  = {2'b01, sml[22:0]};
    mshf  = msml >> ediff;
    msum  = same ? (mbig + mshf) : (mbig - mshf);
  end

  always_comb begin
    S = FP32_POS_ZERO;
    if (fp_is_nan(A) || fp_is_nan(B)) begin
      S = FP32_QNAN;
    end else if (fp_is_inf(A) && fp_is_inf(B)) begin
      S = (A[31] == B[31]) ? A : FP32_QNAN;
    end else if (fp_is_inf(A)) begin
      S = A;
    end else if (fp_is_inf(B)) begin
      S = B;
    end else if (fp_is_zero(A)) begin
      S = B;
    end else if (fp_is_zero(B)) begin
      S = A;
    end else if (msum == 25'd0) begin
      S = FP32_POS_ZERO;
    end else if (msum[24]) begin
      // carry out: shift right once, saturating to infinity at the top
      if (big[30:23] == FP32_EXP_MAX - 8'd1) begin
        S = {big[31], FP32_EXP_MAX, 23'd0};
      end else begin
        S = {big[31], big[30:23] + 8'd1, msum[23:1]};
      end
    end else begin
      S = {big[31], big[30:23], msum[22:0]};
    end
  end

endmodule

// File: rtl/fp32_accum.sv
// Groups up to LEN fp32 terms into one running sum and holds the result
// until the consumer takes it.
module fp32_accum
  import fp32_accum_pkg::*;
#(
  parameter int LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_cnt,
  output logic        out_special
);

  localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

  acc_state_e  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        flag_q, flag_d;
  logic        live_q, live_d;
  logic [31:0] out_data_q, out_data_d;
  logic [7:0]  out_cnt_q, out_cnt_d;
  logic        out_special_q, out_special_d;

  logic [31:0] sum;
  logic        accept;
  logic        close;
  logic        flag_nx;

  fpADD32 u_add (
    .A (acc_q),
    .B (in_data),
    .S (sum)
  );

  // live_q keeps in_ready low until the first edge after reset release
  assign in_ready    = live_q && (state_q == ACCUM);
  assign out_valid   = (state_q == HOLD);
  assign out_data    = out_data_q;
  assign out_cnt     = out_cnt_q;
  assign out_special = out_special_q;

  always_comb begin
    accept        = in_valid & in_ready;
    close         = in_last | (cnt_q == LAST_CNT);
    flag_nx       = flag_q | (sum[30:23] == FP32_EXP_MAX);
    live_d        = 1'b1;
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    flag_d        = flag_q;
    out_data_d    = out_data_q;
    out_cnt_d     = out_cnt_q;
    out_special_d = out_special_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = FP32_POS_ZERO;
      cnt_d   = 8'd0;
      flag_d  = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d  = sum;
            cnt_d  = cnt_q + 8'd1;
            flag_d = flag_nx;
            if (close) begin
              state_d       = HOLD;
              out_data_d    = sum;
              out_cnt_d     = cnt_q + 8'd1;
              out_special_d = flag_nx;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = FP32_POS_ZERO;
            cnt_d   = 8'd0;
            flag_d  = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ACCUM;
      acc_q         <= FP32_POS_ZERO;
      cnt_q         <= 8'd0;
      flag_q        <= 1'b0;
      live_q        <= 1'b0;
      out_data_q    <= FP32_POS_ZERO;
      out_cnt_q     <= 8'd0;
      out_special_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      flag_q        <= flag_d;
      live_q        <= live_d;
      out_data_q    <= out_data_d;
      out_cnt_q     <= out_cnt_d;
      out_special_q <= out_special_d;
    end
  end

endmodule

// File: tb/tb_fp32_accum.sv
// Directed and randomized checks of fp32_accum against a real-valued
// truncating reference model.
module tb_fp32_accum;

  localparam int LEN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_cnt;
  logic        out_special;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp32_accum #(.LEN(LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_cnt     (out_cnt),
    .out_special (out_special)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // exact fp32 -> double (normal values and zero only)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    if (f[30:23] == 8'd0) return 0.0;
    b = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  // double -> fp32 truncating toward zero
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    return {b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
  endfunction

  task automatic push(input logic [31:0] d, input logic last);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 50 && !done; i++) begin
      done = in_ready;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic pull(input string tag, input logic [31:0] d,
                      input logic [7:0] c, input logic s,
                      input int stall);
    int i;
    i = 0;
    while (!out_valid && i < 50) begin
      step();
      i++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_cnt"}, 32'(out_cnt), 32'(c));
    chk({tag, "_special"}, 32'(out_special), 32'(s));
    for (int k = 0; k < stall; k++) begin
      step();
      chk({tag, "_stable"}, out_data, d);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic ones4();
    for (int k = 0; k < 4; k++) push(32'h3F80_0000, 1'b0);
  endtask

  logic [31:0] macc;
  logic [31:0] term;
  int          glen;
  bit          lst;

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_cnt", 32'(out_cnt), 32'd0);
    chk("rst_special", 32'(out_special), 32'd0);
    step();
    step();
    chk("rst_ready_held", 32'(in_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // 1+2+3+4 back-to-back, result one cycle after the 4th accept
    push(32'h3F80_0000, 1'b0);
    push(32'h4000_0000, 1'b0);
    push(32'h4040_0000, 1'b0);
    chk("sum4_no_early", 32'(out_valid), 32'd0);
    push(32'h4080_0000, 1'b0);
    chk("sum4_latency", 32'(out_valid), 32'd1);
    chk("sum4_busy", 32'(in_ready), 32'd0);
    pull("sum4", 32'h4120_0000, 8'd4, 1'b0, 0);

    // early close with in_last
    push(32'h4000_0000, 1'b0);
    push(32'h4040_0000, 1'b1);
    pull("last2", 32'h40A0_0000, 8'd2, 1'b0, 0);

    // stall in HOLD while a term is presented
    push(32'h3F80_0000, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_busy", 32'(in_ready), 32'd0);
      chk("hold_stable", out_data, 32'h3F80_0000);
    end
    in_valid = 1'b0;
    pull("hold", 32'h3F80_0000, 8'd1, 1'b0, 0);
    push(32'h4000_0000, 1'b1);
    pull("after_hold", 32'h4000_0000, 8'd1, 1'b0, 0);

    // infinity sets the sticky flag; next group starts clean
    push(32'h7F80_0000, 1'b0);
    push(32'h3F80_0000, 1'b1);
    pull("inf", 32'h7F80_0000, 8'd2, 1'b1, 0);
    ones4();
    pull("post_inf", 32'h4080_0000, 8'd4, 1'b0, 0);

    // clear mid-group (beating an accept), then clear in HOLD
    push(32'h4000_0000, 1'b0);
    push(32'h4000_0000, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_acc_valid", 32'(out_valid), 32'd0);
    ones4();
    chk("clr_hold_valid", 32'(out_valid), 32'd1);
    clear     = 1'b1;
    out_ready = 1'b1;
    step();
    clear     = 1'b0;
    out_ready = 1'b0;
    chk("clr_hold_drop", 32'(out_valid), 32'd0);
    chk("clr_hold_ready", 32'(in_ready), 32'd1);
    ones4();
    pull("post_clr", 32'h4080_0000, 8'd4, 1'b0, 0);

    // asynchronous reset mid-group and in HOLD
    push(32'h4000_0000, 1'b0);
    push(32'h4000_0000, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_cnt", 32'(out_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    ones4();
    pull("post_arst", 32'h4080_0000, 8'd4, 1'b0, 0);
    push(32'h4000_0000, 1'b1);
    chk("arst_hold_pre", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_hold_valid", 32'(out_valid), 32'd0);
    chk("arst_hold_data", out_data, 32'h0);
    chk("arst_hold_special", 32'(out_special), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    ones4();
    pull("post_arst2", 32'h4080_0000, 8'd4, 1'b0, 0);

    // randomized groups of positive normal terms
    for (int g = 0; g < 60; g++) begin
      glen = $urandom_range(1, LEN);
      macc = 32'h0;
      for (int j = 0; j < glen; j++) begin
        term = {1'b0, 8'($urandom_range(120, 130)), 23'($urandom)};
        macc = r2f(f2r(macc) + f2r(term));
        lst  = (j == glen - 1) &&
               ((glen < LEN) || ($urandom_range(0, 1) == 1));
        for (int w = $urandom_range(0, 2); w > 0; w--) step();
        push(term, lst);
      end
      pull("rnd", macc, 8'(glen), 1'b0, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
